// File: rtl/adder_txn_master_if.sv
// adder_txn_master_if
//   Bundles the three channels around adder_txn_master:
//     req_*   : operand requests (valid/ready), driven by the stimulus source
//     adder_* : operands out to the combinational adder, sum/carry back
//     rsp_*   : buffered results (valid/ready), drained by the consumer
//   modport master : view of adder_txn_master itself
//   modport slave  : view of the surrounding environment (source, adder, consumer)
interface adder_txn_master_if #(
  parameter int N_BIT = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [N_BIT-1:0] req_a;
  logic [N_BIT-1:0] req_b;
  logic             req_cin;

  logic [N_BIT-1:0] adder_a;
  logic [N_BIT-1:0] adder_b;
  logic             adder_cin;
  logic [N_BIT-1:0] adder_sum;
  logic             adder_cout;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [N_BIT-1:0] rsp_sum;
  logic             rsp_cout;

  modport master (
    input  req_valid, req_a, req_b, req_cin,
    output req_ready,
    output adder_a, adder_b, adder_cin,
    input  adder_sum, adder_cout,
    output rsp_valid, rsp_sum, rsp_cout,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_a, req_b, req_cin,
    input  req_ready,
    input  adder_a, adder_b, adder_cin,
    output adder_sum, adder_cout,
    input  rsp_valid, rsp_sum, rsp_cout,
    output rsp_ready
  );
endinterface

// File: rtl/adder_txn_master.sv
// adder_txn_master
//   Accepts one operand transaction at a time, drives it onto an external
//   combinational adder, holds it for SETTLE cycles, then captures sum/cout
//   into a first-word-fall-through response FIFO.
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous reset, active low
//   bus        : adder_txn_master_if.master (req_*, adder_*, rsp_* channels)
//   txn_count  : completed transactions, 16-bit wrapping
//
//   state     | meaning
//   S_IDLE    | waiting for a request; ready only if the FIFO is not full
//   S_DRIVE   | operands held on the adder while the settle counter runs down
//   S_CAPTURE | adder result pushed into the response FIFO
module adder_txn_master #(
  parameter int N_BIT     = 32,
  parameter int SETTLE    = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adder_txn_master_if.master   bus,
  output logic [15:0]          txn_count
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] settle_cnt;
  logic [N_BIT-1:0] adder_a_q, adder_b_q;
  logic             adder_cin_q;

  logic [N_BIT:0]   mem [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, head_idx;
  logic [PTR_W:0]   fill;
  logic             full, empty;

  logic             req_ready_c;
  logic             accept, push, pop;

  assign full  = (fill == (PTR_W+1)'(RSP_DEPTH));
  assign empty = (fill == '0);
  assign pop   = !empty && bus.rsp_ready;

  // FSM next state and strobes
  always_comb begin
    state_nxt   = state;
    req_ready_c = 1'b0;
    accept      = 1'b0;
    push        = 1'b0;
    case (state)
      S_IDLE: begin
        // Registered full only: a same-cycle pop does not open a slot.
        req_ready_c = rst_n && !full;
        if (bus.req_valid && req_ready_c) begin
          accept    = 1'b1;
          state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (settle_cnt == '0) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        // A slot was guaranteed free at accept and nothing else pushes.
        push      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Operand registers and settle counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adder_a_q   <= '0;
      adder_b_q   <= '0;
      adder_cin_q <= 1'b0;
      settle_cnt  <= '0;
    end else if (accept) begin
      adder_a_q   <= bus.req_a;
      adder_b_q   <= bus.req_b;
      adder_cin_q <= bus.req_cin;
      settle_cnt  <= CNT_W'(SETTLE - 1);
    end else if (state == S_DRIVE && settle_cnt != '0) begin
      settle_cnt <= settle_cnt - CNT_W'(1);
    end
  end

  // Response FIFO and transaction counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RSP_DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      txn_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {bus.adder_cout, bus.adder_sum};
        wr_ptr      <= wr_ptr + PTR_W'(1);
        txn_count   <= txn_count + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fill <= fill + (PTR_W+1)'(1);
        2'b01:   fill <= fill - (PTR_W+1)'(1);
        default: fill <= fill;
      endcase
    end
  end

  // When empty, the slot behind rd_ptr still holds the last popped entry
  // (it cannot be overwritten before the FIFO refills), so the outputs hold.
  assign head_idx = empty ? (rd_ptr - PTR_W'(1)) : rd_ptr;

  assign bus.req_ready = req_ready_c;
  assign bus.adder_a   = adder_a_q;
  assign bus.adder_b   = adder_b_q;
  assign bus.adder_cin = adder_cin_q;
  assign bus.rsp_valid = !empty;
  assign bus.rsp_sum   = mem[head_idx][N_BIT-1:0];
  assign bus.rsp_cout  = mem[head_idx][N_BIT];

endmodule
